// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline stage buses and inter-stage buffers.
package pipe_pkg;

  localparam int DEST_W = 5;

  localparam int IF_ID_BUS_W = 64;
  localparam int ID_EX_BUS_W = 150;
  localparam int EX_ME_BUS_W = 71;
  localparam int ME_WB_BUS_W = 70;
  localparam int WB_RF_BUS_W = 38;
  localparam int BR_BUS_W    = 33;

  // Buffer entry for the IF->ID bus; wider stages declare the same shape locally.
  typedef struct packed {
    logic [IF_ID_BUS_W-1:0] bus;
    logic [DEST_W-1:0]      dest;
  } pipe_entry_t;

  // A one-entry buffer still carries a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_ptr_ctr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear; DEPTH need not be a power of two.
module pipe_ptr_ctr
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_fifo.sv
// DEPTH-entry elastic stage buffer with flush and in-flight destination tags.
// Optional zero-latency bypass when empty: define PIPE_FIFO_BYPASS_EN.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter  int BUS_W  = IF_ID_BUS_W,
  parameter  int DEPTH  = 2,
  parameter  int DEST_W = pipe_pkg::DEST_W,
  localparam int PTR_W  = ptr_width(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_allow_in,
  input  logic [BUS_W-1:0]        in_bus,
  input  logic [DEST_W-1:0]       in_dest,
  output logic                    out_valid,
  input  logic                    out_allow_in,
  output logic [BUS_W-1:0]        out_bus,
  output logic [DEST_W-1:0]       out_dest,
  output logic [DEPTH*DEST_W-1:0] occ_dest,
  output logic [DEPTH-1:0]        occ_valid,
  output logic [CNT_W-1:0]        count
);

  typedef struct packed {
    logic [BUS_W-1:0]  bus;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bypass;
  logic             pass;
  logic             enq;
  logic             deq;
  logic             wr_en;
  logic             rd_en;

  // Handshake: a transfer happens on a side when its valid and allow_in are both
  // high at the rising edge and flush is low; a payload offered but not taken
  // stays with the producer, which must hold it unchanged.
  assign in_allow_in = (count < CNT_W'(DEPTH));

`ifdef PIPE_FIFO_BYPASS_EN
  assign bypass = (count == '0) && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (count != '0) || bypass;
  assign enq       = in_valid && in_allow_in && !flush;
  assign deq       = out_valid && out_allow_in && !flush;
  // A payload that passes straight through never occupies a slot.
  assign pass      = bypass && out_allow_in;
  assign wr_en     = enq && !pass;
  assign rd_en     = deq && !pass;

  assign out_bus  = bypass ? in_bus  : mem[rd_ptr].bus;
  assign out_dest = bypass ? in_dest : mem[rd_ptr].dest;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{bus: in_bus, dest: in_dest};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (wr_en && !rd_en) begin
      count <= count + 1'b1;
    end else if (rd_en && !wr_en) begin
      count <= count - 1'b1;
    end
  end

  pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // A slot is live when its distance ahead of rd_ptr (mod DEPTH) is below count.
  always_comb begin
    occ_dest  = '0;
    occ_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      int off;
      off = i - int'(rd_ptr);
      if (off < 0) begin
        off = off + DEPTH;
      end
      occ_dest[i*DEST_W +: DEST_W] = mem[i].dest;
      occ_valid[i] = (off < int'(count)) && (mem[i].dest != '0);
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench for pipe_stage_fifo at DEPTH = 2, 3 and 4 (instances 0, 1, 2).
module tb_pipe_stage_fifo;

  logic        clk;
  logic        reset;
  logic        iv   [3];
  logic [63:0] ib   [3];
  logic [4:0]  id   [3];
  logic        oai  [3];
  logic        fl   [3];
  logic        ia   [3];
  logic        ov   [3];
  logic [63:0] ob   [3];
  logic [4:0]  od   [3];
  logic [19:0] occ_d[3];
  logic [3:0]  occ_v[3];
  logic [2:0]  cnt  [3];

  // Expected payloads in arrival order: {instance, dest, bus}.
  logic [70:0] exp_q[$];
  int          mcount[3];
  int          total;
  int          bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int D  = k + 2;
    localparam int CW = $clog2(D + 1);
    logic [D*5-1:0] od_w;
    logic [D-1:0]   ov_w;
    logic [CW-1:0]  c_w;

    pipe_stage_fifo #(.BUS_W(64), .DEPTH(D), .DEST_W(5)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (fl[k]),
      .in_valid     (iv[k]),
      .in_allow_in  (ia[k]),
      .in_bus       (ib[k]),
      .in_dest      (id[k]),
      .out_valid    (ov[k]),
      .out_allow_in (oai[k]),
      .out_bus      (ob[k]),
      .out_dest     (od[k]),
      .occ_dest     (od_w),
      .occ_valid    (ov_w),
      .count        (c_w)
    );

    assign occ_d[k] = 20'(od_w);
    assign occ_v[k] = 4'(ov_w);
    assign cnt[k]   = 3'(c_w);

    // Monitor: every delivered head must match the oldest expected payload.
    always @(negedge clk) begin
      logic [70:0] e;
      if (!reset && ov[k] && oai[k] && !fl[k]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected inst=%0d act=%h exp=none", k, ob[k]);
        end else begin
          e = exp_q.pop_front();
          chk("mon_inst", 64'(k), 64'(e[70:69]));
          chk("mon_bus",  ob[k],  e[63:0]);
          chk("mon_dest", 64'(od[k]), 64'(e[68:64]));
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Occupied non-zero tags must match the payloads the model holds, as a set.
  task automatic chk_occ(input int k);
    int nz, sm, pv, ps;
    nz = 0; sm = 0; pv = 0; ps = 0;
    foreach (exp_q[j]) begin
      if (exp_q[j][68:64] != 5'd0) begin
        nz++;
        sm += int'(exp_q[j][68:64]);
      end
    end
    for (int i = 0; i < k + 2; i++) begin
      if (occ_v[k][i]) begin
        pv++;
        ps += int'(occ_d[k][i*5 +: 5]);
      end
    end
    chk("occ_popcount", 64'(pv), 64'(nz));
    chk("occ_tag_sum",  64'(ps), 64'(sm));
  endtask

  task automatic chk_occ_set(input int k, input int n, input logic has5, input logic has7);
    int   pv;
    logic f5, f7;
    pv = 0; f5 = 1'b0; f7 = 1'b0;
    for (int i = 0; i < k + 2; i++) begin
      if (occ_v[k][i]) begin
        pv++;
        if (occ_d[k][i*5 +: 5] == 5'd5) f5 = 1'b1;
        if (occ_d[k][i*5 +: 5] == 5'd7) f7 = 1'b1;
      end
    end
    chk("occ_set_n", 64'(pv), 64'(n));
    chk("occ_set_5", 64'(f5), 64'(has5));
    chk("occ_set_7", 64'(f7), 64'(has7));
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, checks registered state, returns at next posedge+1.
  task automatic step(input int k, input logic v, input logic [63:0] b, input logic [4:0] d,
                      input logic oa, input logic f, output logic acc);
    int   dp;
    logic byp, pas, dq;
    dp = k + 2;
    iv[k] = v; ib[k] = b; id[k] = d; oai[k] = oa; fl[k] = f;
    #1;
`ifdef PIPE_FIFO_BYPASS_EN
    byp = (mcount[k] == 0) && v && !f;
`else
    byp = 1'b0;
`endif
    chk("allow_in",  64'(ia[k]),  64'(mcount[k] < dp));
    chk("count",     64'(cnt[k]), 64'(mcount[k]));
    chk("out_valid", 64'(ov[k]),  64'((mcount[k] != 0) || byp));
    chk_occ(k);
    acc = v && !f && (mcount[k] < dp);
    dq  = ((mcount[k] != 0) || byp) && oa && !f;
    pas = byp && oa;
    if (acc) exp_q.push_back({2'(k), d, b});
    @(posedge clk);
    #1;
    if (f) begin
      mcount[k] = 0;
      exp_q.delete();
    end else begin
      if (acc && !pas) mcount[k]++;
      if (dq && !pas)  mcount[k]--;
    end
    iv[k] = 1'b0; oai[k] = 1'b0; fl[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    logic a;
    repeat (k + 4) step(k, 1'b0, 64'd0, 5'd0, 1'b1, 1'b0, a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    int   tries;
    total = 0;
    bad   = 0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ib[k] = '0; id[k] = '0; oai[k] = 1'b0; fl[k] = 1'b0;
      mcount[k] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_allow_in",  64'(ia[k]),    64'd1);
      chk("rst_out_valid", 64'(ov[k]),    64'd0);
      chk("rst_count",     64'(cnt[k]),   64'd0);
      chk("rst_occ_valid", 64'(occ_v[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill/stall on DEPTH 2: A, B fill; C held while full, then A, B, C in order.
    step(0, 1'b1, 64'hA, 5'd1, 1'b0, 1'b0, a);
    step(0, 1'b1, 64'hB, 5'd2, 1'b0, 1'b0, a);
    #1;
    chk("fill_count", 64'(cnt[0]), 64'd2);
    chk("fill_allow", 64'(ia[0]),  64'd0);
    step(0, 1'b1, 64'hC, 5'd3, 1'b0, 1'b0, a);
    step(0, 1'b1, 64'hC, 5'd3, 1'b0, 1'b0, a);
    tries = 0;
    do begin
      step(0, 1'b1, 64'hC, 5'd3, 1'b1, 1'b0, a);
      tries++;
    end while (!a && tries < 20);
    chk("c_accepted", 64'(a), 64'd1);
    drain(0);

    // Asynchronous reset mid-cycle with two entries held.
    step(0, 1'b1, 64'h11, 5'd4, 1'b0, 1'b0, a);
    step(0, 1'b1, 64'h22, 5'd5, 1'b0, 1'b0, a);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count",     64'(cnt[0]),   64'd0);
    chk("arst_out_valid", 64'(ov[0]),    64'd0);
    chk("arst_allow_in",  64'(ia[0]),    64'd1);
    chk("arst_occ_valid", 64'(occ_v[0]), 64'd0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) mcount[k] = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming through DEPTH 3 at occupancy 1: pointers wrap across 2 -> 0.
    step(1, 1'b1, 64'h100, 5'd9, 1'b0, 1'b0, a);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1'b1, 64'h100 + 64'(i), 5'(i), 1'b1, 1'b0, a);
    end
    drain(1);

    // Flush beats same-cycle enqueue and dequeue; the flushed-cycle payload is dropped.
    step(0, 1'b1, 64'hF0, 5'd6, 1'b0, 1'b0, a);
    step(0, 1'b1, 64'hF1, 5'd7, 1'b0, 1'b0, a);
    step(0, 1'b1, 64'hF2, 5'd8, 1'b1, 1'b1, a);
    #1;
    chk("flush_count",     64'(cnt[0]),   64'd0);
    chk("flush_out_valid", 64'(ov[0]),    64'd0);
    chk("flush_occ_valid", 64'(occ_v[0]), 64'd0);
    step(0, 1'b1, 64'hE0, 5'd1, 1'b0, 1'b0, a);
    drain(0);

    // Tag scoreboard on DEPTH 4: dests 5, 0, 7.
    step(2, 1'b1, 64'h5005, 5'd5, 1'b0, 1'b0, a);
    step(2, 1'b1, 64'h5000, 5'd0, 1'b0, 1'b0, a);
    step(2, 1'b1, 64'h5007, 5'd7, 1'b0, 1'b0, a);
    #1;
    chk_occ_set(2, 2, 1'b1, 1'b1);
    step(2, 1'b0, 64'd0, 5'd0, 1'b1, 1'b0, a);
    #1;
    chk_occ_set(2, 1, 1'b0, 1'b1);
    drain(2);

`ifdef PIPE_FIFO_BYPASS_EN
    // Empty buffer passes the payload through in the same cycle.
    iv[0] = 1'b1; ib[0] = 64'h1234; id[0] = 5'd3; oai[0] = 1'b1;
    #1;
    chk("byp_out_valid", 64'(ov[0]),  64'd1);
    chk("byp_out_bus",   ob[0],       64'h1234);
    iv[0] = 1'b0; oai[0] = 1'b0;
    step(0, 1'b1, 64'h1234, 5'd3, 1'b1, 1'b0, a);
    drain(0);
`endif

    // Randomized traffic on every depth.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 250; n++) begin
        logic        rv, ro, rf;
        logic [4:0]  rd;
        rv = ($urandom_range(0, 99) < 70);
        ro = ($urandom_range(0, 99) < 60);
        rf = ($urandom_range(0, 99) < 4);
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        step(k, rv, {$urandom, $urandom}, rd, ro, rf, a);
      end
      drain(k);
    end

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised inter-stage buffer for the five-stage in-order pipeline (IF/ID/EX/ME/WB). It generalises the single-entry stage register to a DEPTH-entry elastic buffer using the same valid/allow_in handshake. It adds a synchronous flush for branch redirect. It also exports the destination-register tags of every occupied entry so the ID interlock logic can scoreboard in-flight writes.

## Interface
- BUS_W, 64, payload width; matches the stage bus it carries, e.g. 64 for IF->ID, 150 for ID->EX.
- DEPTH, 2, number of entries; any value >= 1; DEPTH = 1 behaves as a plain stage register.
- DEST_W, 5, destination-register tag width.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous discard of every entry.
- in_valid  input  1  upstream has a valid payload.
- in_allow_in  output  1  buffer accepts a payload this cycle.
- in_bus  input  BUS_W  upstream payload.
- in_dest  input  DEST_W  destination register of the payload; 0 means no register write.
- out_valid  output  1  head entry is valid.
- out_allow_in  input  1  downstream accepts the head this cycle.
- out_bus  output  BUS_W  head payload.
- out_dest  output  DEST_W  head destination tag.
- occ_dest  output  DEPTH*DEST_W  per-entry tags, indexed by physical slot.
- occ_valid  output  DEPTH  slot occupied and its tag is non-zero.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: circular array of DEPTH entries {bus, dest}, with a write pointer wr_ptr and a read pointer rd_ptr.
- Pointers increment modulo DEPTH using an explicit wrap at DEPTH-1. DEPTH is not required to be a power of two.
- Enqueue fires when in_valid && in_allow_in && !flush: the entry is written at wr_ptr and wr_ptr advances.
- Dequeue fires when out_valid && out_allow_in && !flush: rd_ptr advances.
- in_allow_in = (count < DEPTH). There is no same-cycle pass-through when full, so a full buffer stalls upstream even if downstream drains in that cycle.
- out_valid = (count != 0). out_bus and out_dest come from slot rd_ptr.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- flush has priority over enqueue and dequeue in the same cycle. Next cycle: count = 0, rd_ptr = wr_ptr = 0, and out_valid and occ_valid are all 0.
- Payload and dest storage are not cleared by flush or reset. Only the occupancy state is cleared.
- occ_valid[i] = slot i lies in [rd_ptr, rd_ptr+count) modulo DEPTH && occ_dest slot i != 0.
- in_valid while in_allow_in = 0 is not an error. The payload is simply not taken, and upstream must hold it.

## Timing
- Reset values: in_allow_in = 1, out_valid = 0, count = 0, occ_valid = 0, pointers = 0. out_bus, out_dest and occ_dest are don't-care.
- Reset asserted mid-operation discards all entries asynchronously. The first enqueue is allowed on the first rising edge after reset deasserts.
- Latency without bypass: a payload accepted at edge N is visible on out_* after edge N.
- Throughput: 1 payload per cycle in steady state when DEPTH >= 2. When DEPTH = 1, a full entry and a simultaneous drain cost one bubble.
- in_allow_in and out_valid depend only on registered state. There is no combinational path from out_allow_in to in_allow_in.

## Configuration
- PIPE_FIFO_BYPASS_EN defined: when count == 0 and in_valid && !flush, out_valid = 1 and out_bus/out_dest = in_bus/in_dest combinationally.
  - If out_allow_in is also high, the payload passes through and is not stored (zero latency).
  - Otherwise it is enqueued normally.
  - occ_valid does not include the bypassing payload.
- PIPE_FIFO_BYPASS_EN undefined: strictly registered behaviour as described above.

## Structure
- Shared package pipe_pkg holds:
  - DEST_W = 5.
  - Stage bus widths: IF_ID_BUS_W = 64, ID_EX_BUS_W = 150, EX_ME_BUS_W = 71, ME_WB_BUS_W = 70, WB_RF_BUS_W = 38, BR_BUS_W = 33.
  - The entry typedef {bus, dest}.
- Sub-module pipe_ptr_ctr provides the modulo-DEPTH pointer with increment enable and synchronous clear. It is instantiated for both rd_ptr and wr_ptr.

## Test plan
- Reset: assert reset asynchronously mid-cycle while count = 2. Required: count = 0, out_valid = 0 and in_allow_in = 1 immediately, before the next edge.
- Fill/stall, DEPTH = 2: enqueue 0xA, then 0xB with out_allow_in = 0. Required: count = 2, in_allow_in = 0, and a third payload 0xC is not accepted while held. Raise out_allow_in: outputs appear in order 0xA, 0xB, 0xC.
- Simultaneous enqueue/dequeue, DEPTH = 3, count = 1: stream 10 payloads with out_allow_in = 1. Required: count stays 1, pointers wrap 2->0 with no loss or reorder, and output equals the input sequence delayed by one cycle.
- Flush priority: with count = 2 and flush = 1 in the same cycle as in_valid = 1 and out_allow_in = 1. Required next cycle: count = 0, out_valid = 0, and the flushed-cycle payload is not stored.
- Scoreboard: enqueue dests 5, 0, 7 into DEPTH = 4. Required: occ_valid marks exactly 2 slots, and the occ_dest values of those slots are 5 and 7. After one dequeue, only the slot holding 7 remains valid.
- Bypass (PIPE_FIFO_BYPASS_EN): empty buffer, in_valid = 1, in_bus = 0x1234, out_allow_in = 1. Required: out_valid = 1 and out_bus = 0x1234 in the same cycle, with count staying 0.
